rf_write_trace: RTL

Hardware trace buffer directly downstream of the processor register-file write port. Taps the regfile write strobe, address and data each cycle. Timestamps each architectural write into a FIFO and drains it over a valid/ready stream to the bench or debug logic. Also keeps a shadow copy of all 32 registers, readable through a registered port for end-of-run snapshots.

---
 rtl/rf_trace_pkg.sv | 16 +
 rtl/rf_trace_fifo.sv | 68 ++++++
 rtl/rf_write_trace.sv | 96 +++++++++
 3 files changed

// File: rtl/rf_trace_pkg.sv
// Shared types and constants for the register-file write trace buffer.
package rf_trace_pkg;

    localparam int NUM_REGS = 32;
    localparam logic [15:0] DROP_CNT_MAX = 16'hFFFF;
    localparam int TS_WIDTH_MAX = 32;

    // Timestamp field sized for the widest supported counter; narrower counters zero-extend.
    typedef struct packed {
        logic [4:0]              reg_idx;
        logic [31:0]             data;
        logic [TS_WIDTH_MAX-1:0] ts;
        logic                    lost;
    } trace_entry_t;

endpackage

// File: rtl/rf_trace_fifo.sv
// First-word-fall-through FIFO with registered head, occupancy output and synchronous flush.
module rf_trace_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     valid,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt, level_nxt;
    logic             do_push, do_pop;

    assign level   = wr_ptr - rd_ptr;
    assign full    = (level == {1'b1, {AW{1'b0}}});
    assign do_pop  = pop & valid;
    assign do_push = push & (~full | do_pop);

    always_comb begin
        wr_ptr_nxt = wr_ptr;
        rd_ptr_nxt = rd_ptr;
        if (flush) begin
            wr_ptr_nxt = '0;
            rd_ptr_nxt = '0;
        end else begin
            if (do_push) wr_ptr_nxt = wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr_nxt = rd_ptr + PTR_ONE;
        end
    end

    assign level_nxt = wr_ptr_nxt - rd_ptr_nxt;

    always_ff @(posedge clock) begin
        if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= wdata;
    end

    // Head register looks ahead to the post-edge read pointer; bypass when that slot is being written now.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            valid  <= 1'b0;
            rdata  <= '0;
        end else begin
            wr_ptr <= wr_ptr_nxt;
            rd_ptr <= rd_ptr_nxt;
            valid  <= (level_nxt != '0);
            if (level_nxt == '0)
                rdata <= '0;
            else if (do_push && !flush && (rd_ptr_nxt[AW-1:0] == wr_ptr[AW-1:0]))
                rdata <= wdata;
            else
                rdata <= mem[rd_ptr_nxt[AW-1:0]];
        end
    end

endmodule

// File: rtl/rf_write_trace.sv
// Timestamped trace of architectural register-file writes, with drop accounting
// and a shadow copy of the register file behind a registered read port.
module rf_write_trace
    import rf_trace_pkg::*;
#(
    parameter int DEPTH    = 16,
    parameter int TS_WIDTH = 16,
    parameter bit DROP_R0  = 1'b1
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     rf_we,
    input  logic [4:0]               rf_waddr,
    input  logic [31:0]              rf_wdata,
    input  logic                     enable,
    input  logic                     clear,
    output logic                     trace_valid,
    input  logic                     trace_ready,
    output logic [4:0]               trace_reg,
    output logic [31:0]              trace_data,
    output logic [TS_WIDTH-1:0]      trace_ts,
    output logic                     trace_lost,
    output logic                     overflow,
    output logic [15:0]              dropped_count,
    output logic [$clog2(DEPTH):0]   fifo_level,
    input  logic [4:0]               shadow_addr,
    output logic [31:0]              shadow_data
);

    localparam int ENTRY_W = 5 + 32 + TS_WIDTH + 1;

    logic [TS_WIDTH-1:0] ts_cnt;
    logic                pending_lost;
    logic                eligible, capture, drop, fifo_full;
    logic [ENTRY_W-1:0]  push_entry, head_entry;
    logic [31:0]         shadow [NUM_REGS];

    assign eligible   = rf_we && ((rf_waddr != 5'd0) || !DROP_R0);
    assign capture    = eligible && enable && !clear;
    assign drop       = capture && fifo_full && !(trace_valid && trace_ready);
    assign push_entry = {rf_waddr, rf_wdata, ts_cnt, pending_lost};
    assign {trace_reg, trace_data, trace_ts, trace_lost} = head_entry;

    rf_trace_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .flush   (clear),
        .push    (capture),
        .pop     (trace_ready),
        .wdata   (push_entry),
        .rdata   (head_entry),
        .valid   (trace_valid),
        .full    (fifo_full),
        .level   (fifo_level)
    );

    // The timestamp free-runs through clear so traces stay comparable across flushes.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ts_cnt        <= '0;
            pending_lost  <= 1'b0;
            overflow      <= 1'b0;
            dropped_count <= '0;
        end else begin
            ts_cnt <= ts_cnt + TS_WIDTH'(1);
            if (clear) begin
                pending_lost  <= 1'b0;
                overflow      <= 1'b0;
                dropped_count <= '0;
            end else if (drop) begin
                pending_lost <= 1'b1;
                overflow     <= 1'b1;
                if (dropped_count != DROP_CNT_MAX) dropped_count <= dropped_count + 16'd1;
            end else if (capture) begin
                pending_lost <= 1'b0;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) shadow[i] <= '0;
            shadow_data <= '0;
        end else begin
            if (eligible) shadow[rf_waddr] <= rf_wdata;
            if (eligible && (rf_waddr == shadow_addr))
                shadow_data <= rf_wdata;
            else
                shadow_data <= shadow[shadow_addr];
        end
    end

endmodule
